mmio_timer: RTL and testbench

MMIO_TIMER -- requirements
Module: mmio_timer

---
 rtl/mmio_timer.sv | 163 ++++++++++++++++
 tb/tb_mmio_timer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_timer.sv
// mmio_timer: memory-mapped down-counting timer (CTRL / PRESET / COUNT) with a maskable interrupt.
// Optional feature: define TIMER_AUTORELOAD_EN to make MODE 01 re-arm automatically; otherwise every count is one-shot.
module mmio_timer #(
  parameter logic [31:0] BASE = 32'h0000_7f00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [3:0]  byteen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  // state | meaning
  // IDLE  | timer parked, waiting for EN
  // LOAD  | COUNT takes PRESET
  // CNT   | COUNT decrementing toward expiry
  // INT   | expiry seen; one-shot drops EN, auto-reload clears the flag and re-arms
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  localparam logic [1:0] OFF_CTRL   = 2'd0;
  localparam logic [1:0] OFF_PRESET = 2'd1;
  localparam logic [1:0] OFF_COUNT  = 2'd2;

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_en;
  logic        r_im;
  logic        r_irq_flag;
  logic [1:0]  r_mode;
  logic [31:0] r_preset;
  logic [31:0] r_count;

  logic        w_sel;
  logic [1:0]  w_off;
  logic        w_wr;
  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic [1:0]  w_mode_wr;
  logic        w_reload_mode;
  logic [31:0] w_count_nxt;
  logic        w_en_clr;
  logic        w_flag_set;
  logic        w_flag_clr;
  logic        w_unused_addr;

  assign w_sel         = (addr[31:4] == BASE[31:4]);
  assign w_off         = addr[3:2];
  assign w_wr          = w_sel && (byteen == 4'b1111);
  assign w_wr_ctrl     = w_wr && (w_off == OFF_CTRL);
  assign w_wr_preset   = w_wr && (w_off == OFF_PRESET);
  assign w_unused_addr = ^addr[1:0];

`ifdef TIMER_AUTORELOAD_EN
  assign w_mode_wr     = wdata[2:1];
  assign w_reload_mode = (r_mode == 2'b01);
`else
  // Without auto-reload the MODE field is hardwired so software sees 00.
  assign w_mode_wr     = 2'b00;
  assign w_reload_mode = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_en_clr    = 1'b0;
    w_flag_set  = 1'b0;
    w_flag_clr  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_en) begin
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_count_nxt = r_preset;
        w_state_nxt = S_CNT;
      end
      S_CNT: begin
        if (!r_en) begin
          w_state_nxt = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_count_nxt = r_count - 32'd1;
        end else begin
          // PRESET of 0 or 1 expires on the first CNT cycle.
          w_count_nxt = '0;
          w_flag_set  = 1'b1;
          w_state_nxt = S_INT;
        end
      end
      S_INT: begin
        if (w_reload_mode) begin
          w_flag_clr = 1'b1;
        end else begin
          w_en_clr = 1'b1;
        end
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_en       <= 1'b0;
      r_mode     <= 2'b00;
      r_im       <= 1'b0;
      r_irq_flag <= 1'b0;
      r_preset   <= '0;
      r_count    <= '0;
    end else begin
      r_count <= w_count_nxt;
      // A CPU write to CTRL overrides whatever the FSM wanted for EN and the flag.
      if (w_wr_ctrl) begin
        r_en       <= wdata[0];
        r_mode     <= w_mode_wr;
        r_im       <= wdata[3];
        r_irq_flag <= 1'b0;
      end else begin
        if (w_en_clr) begin
          r_en <= 1'b0;
        end
        if (w_flag_set) begin
          r_irq_flag <= 1'b1;
        end else if (w_flag_clr) begin
          r_irq_flag <= 1'b0;
        end
      end
      if (w_wr_preset) begin
        r_preset <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (w_sel) begin
      case (w_off)
        OFF_CTRL:   rdata = {28'b0, r_im, r_mode, r_en};
        OFF_PRESET: rdata = r_preset;
        OFF_COUNT:  rdata = r_count;
        default:    rdata = '0;
      endcase
    end
  end

  assign irq = r_irq_flag & r_im;

endmodule

// File: tb/tb_mmio_timer.sv
// tb_mmio_timer: directed scenarios plus random MMIO traffic against a timeline-based reference model.
// Honours TIMER_AUTORELOAD_EN the same way the design does.
`timescale 1ns/1ps
module tb_mmio_timer;

  localparam logic [31:0] BASE = 32'h0000_7f00;
`ifdef TIMER_AUTORELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] addr = '0;
  logic [3:0]  byteen = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic        irq;

  mmio_timer #(.BASE(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .byteen(byteen),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: register file plus a schedule of edge numbers at which
  // the timer loads, expires and resolves its expiry.
  logic        m_en, m_im, m_flag, m_run;
  logic [1:0]  m_mode;
  logic [31:0] m_preset, m_count, m_base;
  longint      e_now = 0;
  longint      t_ld, t_lded, t_exp, t_res;

  logic [31:0] obs_rd;
  logic        obs_irq;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = 0; m_im = 0; m_flag = 0; m_run = 0; m_mode = 0;
    m_preset = 0; m_count = 0; m_base = 0;
    t_ld = -1; t_lded = -1; t_exp = -1; t_res = -1;
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] a);
    if (a[31:4] != BASE[31:4]) return 32'h0;
    case (a[3:2])
      2'd0:    return {28'b0, m_im, m_mode, m_en};
      2'd1:    return m_preset;
      2'd2:    return m_count;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    e_now++;
    if (t_res == e_now) begin
      if (AR && m_mode == 2'b01) m_flag = 0;
      else m_en = 0;
      t_res = -1;
    end else if (t_ld == e_now) begin
      m_count = m_preset;
      m_base  = m_preset;
      t_lded  = e_now;
      t_exp   = e_now + ((m_preset > 32'd1) ? longint'(m_preset) : 64'sd1);
      m_run   = 1;
      t_ld    = -1;
    end else if (m_run) begin
      if (!m_en) m_run = 0;
      else if (e_now == t_exp) begin
        m_count = 0; m_flag = 1; m_run = 0; t_res = e_now + 1;
      end else m_count = m_base - 32'(e_now - t_lded);
    end else if (m_en) begin
      t_ld = e_now + 1;
    end
    if (a[31:4] == BASE[31:4] && be == 4'hF) begin
      if (a[3:2] == 2'd0) begin
        m_en = wd[0]; m_mode = AR ? wd[2:1] : 2'b00; m_im = wd[3]; m_flag = 0;
      end else if (a[3:2] == 2'd1) begin
        m_preset = wd;
      end
    end
  endtask

  // Called with the clock low; returns at the following negedge after checking.
  task automatic cycle(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    addr = a; byteen = be; wdata = wd;
    @(posedge clk);
    model_edge(a, be, wd);
    @(negedge clk);
    obs_rd  = rdata;
    obs_irq = irq;
    chk($sformatf("rd_off%0d", a[3:2]), rdata, model_rd(a));
    chk("irq", 32'(irq), 32'(m_flag & m_im));
  endtask

  task automatic quiesce();
    cycle(BASE, 4'hF, 32'h0);
    repeat (3) cycle(BASE + 8, 4'h0, 32'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a, wd;
    logic [3:0]  be;
    int          r;
    int          pulses;

    model_reset();
    #3;
    for (int o = 0; o < 5; o++) begin
      addr = BASE + 32'(o * 4);
      #1;
      chk("rst_rd", rdata, 32'h0);
    end
    chk("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // One-shot, PRESET=5, IM=1
    cycle(BASE + 4, 4'hF, 32'd5);
    cycle(BASE, 4'hF, 32'h9);
    chk("ctrl_E0", obs_rd, 32'h9);
    cycle(BASE + 8, 4'h0, 32'h0);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("cnt_E2", obs_rd, 32'd5);
    repeat (3) cycle(BASE + 8, 4'h0, 32'h0);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("cnt_E6", obs_rd, 32'd1);
    chk("irq_E6", 32'(obs_irq), 32'h0);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("irq_E7", 32'(obs_irq), 32'h1);
    cycle(BASE, 4'h0, 32'h0);
    chk("ctrl_E8", obs_rd, 32'h8);
    cycle(BASE, 4'hF, 32'h0);
    chk("irq_clr", 32'(obs_irq), 32'h0);

    // Masked expiry keeps irq low
    cycle(BASE + 4, 4'hF, 32'd2);
    cycle(BASE, 4'hF, 32'h1);
    repeat (6) cycle(BASE + 8, 4'h0, 32'h0);
    quiesce();

    // COUNT write and partial PRESET write ignored; PRESET change mid-count deferred
    cycle(BASE + 4, 4'hF, 32'd20);
    cycle(BASE, 4'hF, 32'h9);
    repeat (4) cycle(BASE + 8, 4'h0, 32'h0);
    cycle(BASE + 8, 4'hF, 32'h0000_FFFF);
    cycle(BASE + 4, 4'b0011, 32'h0000_1234);
    chk("preset_keep", obs_rd, 32'd20);
    cycle(BASE + 4, 4'hF, 32'd3);
    repeat (3) cycle(BASE + 8, 4'h0, 32'h0);
    quiesce();

    // Unmapped offsets; PRESET=0 latency
    cycle(BASE + 12, 4'hF, 32'hDEAD_BEEF);
    chk("off3_rd", obs_rd, 32'h0);
    cycle(BASE + 16, 4'hF, 32'h1);
    chk("unsel_rd", obs_rd, 32'h0);
    cycle(BASE + 4, 4'hF, 32'd0);
    cycle(BASE, 4'hF, 32'h9);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("p0_E1", 32'(obs_irq), 32'h0);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("p0_E2", 32'(obs_irq), 32'h0);
    cycle(BASE + 8, 4'h0, 32'h0);
    chk("p0_E3", 32'(obs_irq), 32'h1);
    quiesce();

    // MODE 01: periodic pulses with the macro, sticky one-shot without
    cycle(BASE + 4, 4'hF, 32'd3);
    cycle(BASE, 4'hF, 32'hB);
    chk("ctrl_mode", obs_rd, AR ? 32'hB : 32'h9);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      cycle(BASE + 8, 4'h0, 32'h0);
      if (obs_irq) pulses++;
    end
    chk("irq_pulses", 32'(pulses), AR ? 32'd2 : 32'd10);
    quiesce();

    // Random MMIO traffic
    for (int i = 0; i < 3000; i++) begin
      r  = int'($urandom_range(0, 99));
      a  = BASE + ($urandom_range(0, 3) << 2);
      be = 4'h0;
      wd = $urandom;
      if (r < 5) begin
        a = BASE; be = 4'hF;
        wd[0] = ($urandom_range(0, 3) != 0);
      end else if (r < 10) begin
        a = BASE + 4; be = 4'hF; wd = $urandom_range(0, 12);
      end else if (r < 14) begin
        be = 4'($urandom_range(1, 14));
      end else if (r < 17) begin
        a = BASE + 8 + ($urandom_range(0, 1) << 2); be = 4'hF;
      end else if (r < 19) begin
        a = BASE + 32'h10 * $urandom_range(1, 64); be = 4'hF;
      end
      cycle(a, be, wd);
    end
    quiesce();

    // Reset in the middle of a count
    cycle(BASE + 4, 4'hF, 32'd10);
    cycle(BASE, 4'hF, 32'h9);
    repeat (5) cycle(BASE + 8, 4'h0, 32'h0);
    chk("cnt7", obs_rd, 32'd7);
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_cnt", rdata, 32'h0);
    chk("rst_irq2", 32'(irq), 32'h0);
    for (int o = 0; o < 4; o++) begin
      addr = BASE + 32'(o * 4);
      #0.5;
      chk("rst_rd2", rdata, 32'h0);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < 8; k++) begin
      cycle(BASE + 32'((k % 4) * 4), 4'h0, 32'h0);
      chk("post_rst", obs_rd, 32'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
